blk_addr_alloc: RTL and testbench
=================================

Name: blk_addr_alloc

Overview:
- Free-block address manager feeding the ingress write controller: answers each single-cycle address request with one block base address and recycles freed blocks returned by the egress/read side.
- Holds a FIFO free list of block indices in a local register array, self-initialised after reset with every block in the shared packet SRAM.
- Packet SRAM is divided into BLK_NUM blocks of BLK_WORDS words. Block base address = index * BLK_WORDS.

Parameters:
- ADDR_W, 12, width of block/SRAM word address (matches `BLK_ADDR_WIDTH).
- BLK_NUM, 256, number of blocks; power of two; BLK_NUM*BLK_WORDS = 2^ADDR_W.
- BLK_WORDS, 16, words per block; power of two; IDX_W = ADDR_W - log2(BLK_WORDS) = 8.
- PEND_MAX, 7, max outstanding unserved requests; pending counter is 3 bits.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_addr_req, in, 1, single-cycle request for one block.
- o_blk_addr_vld, out, 1, single-cycle grant pulse.
- o_blk_addr, out, ADDR_W, granted block base address; 0 when o_blk_addr_vld=0.
- i_free_vld, in, 1, return one block to the free list.
- i_free_addr, in, ADDR_W, base address of the returned block.
- o_init_done, out, 1, free list fully loaded; stays high until reset.
- o_free_cnt, out, IDX_W+1, number of blocks currently in the free list.
- o_empty, out, 1, o_free_cnt==0.
- o_free_err, out, 1, pulse: free request rejected.
- o_req_ovf, out, 1, pulse: request dropped because pending count is saturated.

Behaviour:
- Reset (async, any time, including mid-operation): all outputs 0; wr_ptr/rd_ptr/count/pending = 0; state = S_INIT; init index = 0. Array contents are don't-care.
- S_INIT:
  - Each posedge writes entry[init_idx] = init_idx and increments init_idx.
  - The posedge writing index BLK_NUM-1 sets count = BLK_NUM, wr_ptr = 0 (wrapped), rd_ptr = 0, o_init_done = 1, and moves to S_RUN.
  - o_init_done is therefore high after the 256th posedge following reset release.
- Requests during S_INIT: each i_addr_req increments pending (saturating). Frees during S_INIT: rejected with o_free_err pulse.
- S_RUN grant rule, evaluated each cycle using registered count and pending:
  - want = i_addr_req | (pending != 0).
  - If want and count != 0: pop entry[rd_ptr], rd_ptr++ (wraps mod BLK_NUM).
  - Next cycle: o_blk_addr_vld = 1 and o_blk_addr = {entry, log2(BLK_WORDS) zero bits}.
  - Latency request-to-grant = 1 cycle when the list is non-empty and nothing is pending.
  - At most one grant per cycle.
- Pending update: pending_next = pending + i_addr_req - grant.
  - If pending == PEND_MAX, i_addr_req=1 and no grant: request dropped, o_req_ovf pulse, pending stays PEND_MAX.
- Free acceptance: i_free_vld with low log2(BLK_WORDS) bits of i_free_addr nonzero, or count == BLK_NUM, or state == S_INIT: ignored, o_free_err = 1 next cycle. Otherwise entry[wr_ptr] = i_free_addr[ADDR_W-1:log2(BLK_WORDS)], wr_ptr++ (wraps).
- count_next = count + free_accepted - grant. A simultaneous grant and free leaves count unchanged.
- A grant decision uses the pre-update count; no bypass. A freed block on an empty list is grantable from the following cycle, giving vld 2 cycles after the free.
- Free-list order is strict FIFO.
- o_free_cnt and o_empty are driven from registered count.
- Error pulses last exactly one cycle.

Test Plan:
- Release reset, no traffic → o_init_done rises after 256 posedges; o_free_cnt=256; o_empty=0; no grants during init.
- Two i_addr_req pulses right after o_init_done → grants 0x000 then 0x010, each 1 cycle after its request; o_free_cnt=254.
- 3 requests during S_INIT → after init, grants 0x000, 0x010, 0x020 on consecutive cycles; pending returns to 0.
- Allocate all 256, then request again → no grant, o_empty=1, pending=1. Free 0x0A0 → grant 0x0A0 two cycles after the free; pending=0.
- Free 0x015 (misaligned) and free when o_free_cnt=256 → o_free_err pulse each; count unchanged. Simultaneous req+free on 10 blocks → count constant, freed block returned after remaining FIFO entries.
- Empty list with 8 requests → 8th gives o_req_ovf; after 7 frees, exactly 7 grants. Assert reset mid-grant → all outputs 0 immediately; init restarts from index 0.

Source files
------------

// File: rtl/blk_addr_alloc.sv
// rtl/blk_addr_alloc.sv - FIFO free-list block address allocator for the shared packet SRAM
module blk_addr_alloc #(
  parameter int ADDR_W    = 12,
  parameter int BLK_NUM   = 256,
  parameter int BLK_WORDS = 16,
  parameter int PEND_MAX  = 7
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_addr_req,
  output logic                                   o_blk_addr_vld,
  output logic [ADDR_W-1:0]                      o_blk_addr,
  input  logic                                   i_free_vld,
  input  logic [ADDR_W-1:0]                      i_free_addr,
  output logic                                   o_init_done,
  output logic [ADDR_W-$clog2(BLK_WORDS):0]      o_free_cnt,
  output logic                                   o_empty,
  output logic                                   o_free_err,
  output logic                                   o_req_ovf
);

  localparam int OFF_W  = $clog2(BLK_WORDS);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int PEND_W = $clog2(PEND_MAX + 1);
  localparam logic [IDX_W:0]    CNT_FULL = (IDX_W + 1)'(BLK_NUM);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLK_NUM - 1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    mem [BLK_NUM];
  logic [IDX_W-1:0]    wr_ptr, rd_ptr, init_idx;
  logic [IDX_W:0]      count;
  logic [PEND_W-1:0]   pending, pend_next;
  logic                grant, free_acc, free_rej, ovf;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr, mem_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == S_INIT && init_idx == IDX_LAST) state_next = S_RUN;
  end

  // Grant and free decisions use the registered count only; a free never bypasses to a grant.
  always_comb begin
    grant     = 1'b0;
    free_acc  = 1'b0;
    free_rej  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = i_free_addr[ADDR_W-1:OFF_W];
    case (state)
      S_INIT: begin
        free_rej  = i_free_vld;
        mem_we    = 1'b1;
        mem_waddr = init_idx;
        mem_wdata = init_idx;
      end
      S_RUN: begin
        grant = (i_addr_req || pending != '0) && count != '0;
        if (i_free_vld) begin
          if (|i_free_addr[OFF_W-1:0] || count == CNT_FULL) free_rej = 1'b1;
          else                                                free_acc = 1'b1;
        end
        mem_we = free_acc;
      end
      default: ;
    endcase
    ovf       = i_addr_req && !grant && pending == PEND_TOP;
    pend_next = ovf ? pending : pending + PEND_W'(i_addr_req) - PEND_W'(grant);
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      init_idx       <= '0;
      count          <= '0;
      pending        <= '0;
      o_init_done    <= 1'b0;
      o_blk_addr_vld <= 1'b0;
      o_blk_addr     <= '0;
      o_free_err     <= 1'b0;
      o_req_ovf      <= 1'b0;
    end else begin
      if (state == S_INIT) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == IDX_LAST) begin
          count       <= CNT_FULL;
          wr_ptr      <= '0;
          rd_ptr      <= '0;
          o_init_done <= 1'b1;
        end
      end else begin
        if (grant)    rd_ptr <= rd_ptr + 1'b1;
        if (free_acc) wr_ptr <= wr_ptr + 1'b1;
        count <= count + (IDX_W + 1)'(free_acc) - (IDX_W + 1)'(grant);
      end
      pending        <= pend_next;
      o_blk_addr_vld <= grant;
      o_blk_addr     <= grant ? {mem[rd_ptr], {OFF_W{1'b0}}} : '0;
      o_free_err     <= free_rej;
      o_req_ovf      <= ovf;
    end
  end

  assign o_free_cnt = count;
  assign o_empty    = (state == S_RUN) && count == '0;

endmodule

// File: tb/tb_blk_addr_alloc.sv
// tb/tb_blk_addr_alloc.sv - directed self-checking bench for blk_addr_alloc
module tb_blk_addr_alloc;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_addr_req;
  logic        o_blk_addr_vld;
  logic [11:0] o_blk_addr;
  logic        i_free_vld;
  logic [11:0] i_free_addr;
  logic        o_init_done;
  logic [8:0]  o_free_cnt;
  logic        o_empty;
  logic        o_free_err;
  logic        o_req_ovf;

  int checks   = 0;
  int failures = 0;

  blk_addr_alloc dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_addr_req     (i_addr_req),
    .o_blk_addr_vld (o_blk_addr_vld),
    .o_blk_addr     (o_blk_addr),
    .i_free_vld     (i_free_vld),
    .i_free_addr    (i_free_addr),
    .o_init_done    (o_init_done),
    .o_free_cnt     (o_free_cnt),
    .o_empty        (o_empty),
    .o_free_err     (o_free_err),
    .o_req_ovf      (o_req_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_init(output int n, output int g);
    n = 0;
    g = 0;
    while (!o_init_done && n < 300) begin
      tick();
      n++;
      if (o_blk_addr_vld) g++;
    end
  endtask

  task automatic do_reset();
    i_rst_n     = 1'b0;
    i_addr_req  = 1'b0;
    i_free_vld  = 1'b0;
    i_free_addr = '0;
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    logic [11:0] exp_a;
    logic [11:0] got_q [$];

    // Reset state and self-initialisation
    i_rst_n     = 1'b0;
    i_addr_req  = 1'b0;
    i_free_vld  = 1'b0;
    i_free_addr = '0;
    tick();
    tick();
    check("rst_vld", o_blk_addr_vld, 0);
    check("rst_addr", o_blk_addr, 0);
    check("rst_init_done", o_init_done, 0);
    check("rst_free_cnt", o_free_cnt, 0);
    check("rst_empty", o_empty, 0);
    check("rst_free_err", o_free_err, 0);
    check("rst_req_ovf", o_req_ovf, 0);
    i_rst_n = 1'b1;
    wait_init(n, g);
    check("init_cycles", n, 256);
    check("init_no_grant", g, 0);
    check("init_free_cnt", o_free_cnt, 256);
    check("init_empty", o_empty, 0);

    // Free on a full list is rejected
    i_free_vld = 1'b1; i_free_addr = 12'h000;
    tick();
    i_free_vld = 1'b0;
    check("full_free_err", o_free_err, 1);
    check("full_free_cnt", o_free_cnt, 256);
    tick();
    check("full_free_err_pulse", o_free_err, 0);

    // Two single requests, one-cycle latency each
    i_addr_req = 1'b1; tick(); i_addr_req = 1'b0;
    check("req1_vld", o_blk_addr_vld, 1);
    check("req1_addr", o_blk_addr, 12'h000);
    i_addr_req = 1'b1; tick(); i_addr_req = 1'b0;
    check("req2_vld", o_blk_addr_vld, 1);
    check("req2_addr", o_blk_addr, 12'h010);
    tick();
    check("req_idle_vld", o_blk_addr_vld, 0);
    check("req_idle_addr", o_blk_addr, 0);
    check("req_free_cnt", o_free_cnt, 254);

    // Requests and a free during init
    do_reset();
    i_addr_req = 1'b1;
    tick(); tick(); tick();
    i_addr_req = 1'b0;
    i_free_vld = 1'b1; i_free_addr = 12'h020;
    tick();
    i_free_vld = 1'b0;
    check("init_free_err", o_free_err, 1);
    wait_init(n, g);
    check("init2_cycles", n, 252);
    check("init2_no_grant", g, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pend_vld", o_blk_addr_vld, 1);
      check("pend_addr", o_blk_addr, 12'(i * 16));
    end
    tick();
    check("pend_drained_vld", o_blk_addr_vld, 0);
    check("pend_free_cnt", o_free_cnt, 253);

    // Allocate everything, then request on an empty list
    i_addr_req = 1'b1;
    for (int i = 0; i < 253; i++) begin
      tick();
      exp_a = 12'((3 + i) * 16);
      check("alloc_vld", o_blk_addr_vld, 1);
      check("alloc_addr", o_blk_addr, exp_a);
    end
    check("alloc_empty", o_empty, 1);
    check("alloc_free_cnt", o_free_cnt, 0);
    tick();
    i_addr_req = 1'b0;
    check("empty_no_grant", o_blk_addr_vld, 0);
    tick();
    check("empty_still_no_grant", o_blk_addr_vld, 0);
    i_free_vld = 1'b1; i_free_addr = 12'h0A0;
    tick();
    i_free_vld = 1'b0;
    check("free_a0_no_bypass", o_blk_addr_vld, 0);
    check("free_a0_cnt", o_free_cnt, 1);
    tick();
    check("free_a0_vld", o_blk_addr_vld, 1);
    check("free_a0_addr", o_blk_addr, 12'h0A0);
    check("free_a0_cnt_after", o_free_cnt, 0);
    i_free_vld = 1'b1; i_free_addr = 12'h100;
    tick();
    i_free_vld = 1'b0;
    tick();
    check("pend_cleared_vld", o_blk_addr_vld, 0);
    check("pend_cleared_cnt", o_free_cnt, 1);

    // Misaligned free
    i_free_vld = 1'b1; i_free_addr = 12'h015;
    tick();
    i_free_vld = 1'b0;
    check("misalign_err", o_free_err, 1);
    check("misalign_cnt", o_free_cnt, 1);
    tick();
    check("misalign_err_pulse", o_free_err, 0);

    // Simultaneous request and free keeps count constant; FIFO order holds
    i_free_vld = 1'b1; i_free_addr = 12'h200; tick();
    i_free_addr = 12'h210; tick();
    for (int i = 0; i < 10; i++) begin
      i_addr_req  = 1'b1;
      i_free_vld  = 1'b1;
      i_free_addr = 12'(12'h300 + i * 16);
      tick();
      case (i)
        0: exp_a = 12'h100;
        1: exp_a = 12'h200;
        2: exp_a = 12'h210;
        default: exp_a = 12'(12'h300 + (i - 3) * 16);
      endcase
      check("sim_vld", o_blk_addr_vld, 1);
      check("sim_addr", o_blk_addr, exp_a);
      check("sim_cnt", o_free_cnt, 3);
    end
    i_free_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_addr", o_blk_addr, 12'(12'h370 + i * 16));
    end
    i_addr_req = 1'b0;
    tick();
    check("drain_empty", o_empty, 1);

    // Pending saturation and overflow
    i_addr_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("ovf_pulse", o_req_ovf, (k == 8) ? 1 : 0);
    end
    i_addr_req = 1'b0;
    tick();
    check("ovf_one_cycle", o_req_ovf, 0);
    for (int i = 0; i < 7; i++) begin
      i_free_vld  = 1'b1;
      i_free_addr = 12'(12'h400 + i * 16);
      tick();
      if (o_blk_addr_vld) got_q.push_back(o_blk_addr);
    end
    i_free_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_blk_addr_vld) got_q.push_back(o_blk_addr);
    end
    check("ovf_grant_count", got_q.size(), 7);
    for (int i = 0; i < got_q.size() && i < 7; i++)
      check("ovf_grant_addr", got_q[i], 12'(12'h400 + i * 16));
    check("ovf_final_cnt", o_free_cnt, 0);

    // Reset in the middle of a grant
    i_free_vld = 1'b1; i_free_addr = 12'h500; tick();
    i_free_vld = 1'b0;
    i_addr_req = 1'b1; tick();
    i_addr_req = 1'b0;
    check("pre_rst_vld", o_blk_addr_vld, 1);
    check("pre_rst_addr", o_blk_addr, 12'h500);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_vld", o_blk_addr_vld, 0);
    check("mid_rst_addr", o_blk_addr, 0);
    check("mid_rst_init_done", o_init_done, 0);
    check("mid_rst_cnt", o_free_cnt, 0);
    tick();
    i_rst_n = 1'b1;
    wait_init(n, g);
    check("reinit_cycles", n, 256);
    i_addr_req = 1'b1; tick(); i_addr_req = 1'b0;
    check("reinit_vld", o_blk_addr_vld, 1);
    check("reinit_addr", o_blk_addr, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
